frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: steps through NUM_FRAMES frame buffers (loop/ping-pong/one-shot/manual) with a dwell timer.
// Define FRAME_SEQ_WRAP_PULSE_EN to enable the out_wrap sequence-event pulse; otherwise out_wrap is tied low.
module frame_sequencer #(
  parameter int NUM_FRAMES  = 2,
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 6,
  parameter int TIMER_WIDTH = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       in_mode,
  input  logic [TIMER_WIDTH-1:0]           in_dwell,
  input  logic                             in_pause,
  input  logic [2:0]                       in_frame_sel,
  input  logic                             in_rd,
  input  logic [ADDR_WIDTH-1:0]            in_ADDR,
  input  logic [NUM_FRAMES*DATA_WIDTH-1:0] in_frames_data,
  input  logic [NUM_FRAMES-1:0]            in_charged,
  output logic [NUM_FRAMES-1:0]            out_rd,
  output logic [ADDR_WIDTH-1:0]            out_ADDR,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [2:0]                       out_frame_idx,
  output logic                             out_reg_RST,
  output logic                             out_busy,
  output logic                             out_wrap
);
  typedef enum logic [1:0] {SWITCHING, LOADING, SHOWING} state_t;
  localparam logic [2:0] LAST = 3'(NUM_FRAMES - 1);
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d, step_idx;
  logic dir_q, dir_d, step_dir, down, expire, oneshot_done;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d, dwell_eff;
  logic [TIMER_WIDTH:0] timer_inc;
  logic [NUM_FRAMES-1:0] idx_oh;
  assign idx_oh        = NUM_FRAMES'(1) << idx_q;
  assign out_rd        = (in_rd && state_q == SHOWING) ? idx_oh : '0;
  assign out_ADDR      = in_ADDR;
  assign out_data      = in_frames_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign out_frame_idx = idx_q;
  assign out_reg_RST   = state_q == SWITCHING;
  assign out_busy      = state_q != SHOWING;
  // dir=1 means stepping down; an index at the top end always steps down
  always_comb begin
    down     = (dir_q && idx_q != 3'd0) || idx_q == LAST;
    step_idx = in_mode == 2'b00 ? (idx_q == LAST ? 3'd0 : idx_q + 3'd1) :
               in_mode == 2'b01 ? (down ? idx_q - 3'd1 : idx_q + 3'd1) : idx_q + 3'd1;
    step_dir = in_mode == 2'b01 && (step_idx == 3'd0 ? 1'b0 : step_idx == LAST ? 1'b1 : down);
  end
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    dir_d        = in_mode == 2'b01 ? dir_q : 1'b0;
    dwell_eff    = in_dwell == '0 ? TIMER_WIDTH'(1) : in_dwell;
    timer_inc    = {1'b0, timer_q} + (TIMER_WIDTH+1)'(1);
    expire       = timer_inc >= {1'b0, dwell_eff};
    oneshot_done = in_mode == 2'b10 && idx_q == LAST;
    case (state_q)
      SWITCHING: begin
        state_d = LOADING;
        timer_d = '0;
      end
      LOADING: state_d = |(in_charged & idx_oh) ? SHOWING : LOADING;
      SHOWING: begin
        if (in_mode == 2'b11) begin
          if (in_frame_sel <= LAST && in_frame_sel != idx_q) begin
            state_d = SWITCHING;
            idx_d   = in_frame_sel;
          end
        end else if (!in_pause && !oneshot_done) begin
          timer_d = timer_inc[TIMER_WIDTH-1:0];
          if (expire) begin
            state_d = SWITCHING;
            idx_d   = step_idx;
            dir_d   = step_dir;
          end
        end
      end
      default: state_d = SWITCHING;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SWITCHING;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end
`ifdef FRAME_SEQ_WRAP_PULSE_EN
  logic wrap_q, wrap_d, step_wrap;
  assign step_wrap = in_mode == 2'b01 ? (step_idx == 3'd0 || step_idx == LAST) :
                     in_mode == 2'b00 ? step_idx == 3'd0 : step_idx == LAST;
  assign wrap_d    = state_q == SHOWING && state_d == SWITCHING && in_mode != 2'b11 && step_wrap;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wrap_q <= 1'b0;
    else wrap_q <= wrap_d;
  end
  assign out_wrap = wrap_q;
`else
  assign out_wrap = 1'b0;
`endif
endmodule
